// File: rtl/uart_receiver.sv
// UART receive path: two-flop synchroniser, mid-bit sampling FSM and a
// valid/ack holding register carrying parity, framing and overrun flags.
module uart_receiver #(
   parameter int CLOCK_DIVISOR_WIDTH = 24
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           rx,
   input  logic [1:0]                     dataBits,
   input  logic                           hasParity,
   input  logic [1:0]                     parityMode,
   input  logic                           extraStopBit,
   input  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
   output logic [7:0]                     data,
   output logic                           valid,
   input  logic                           ack,
   output logic                           parityError,
   output logic                           framingError,
   output logic                           overrun,
   output logic                           busy
);
   localparam int CW = CLOCK_DIVISOR_WIDTH + 3;

   typedef enum logic [2:0] {
      IDLE, START, DATA, PAR, STOP1, STOP2, DONE, BREAKWAIT
   } state_t;

   state_t                         state, state_next;
   logic                           rx_meta, rxs;
   logic [CW-1:0]                  cnt, cnt_next;
   logic [2:0]                     bit_idx, bit_idx_next;
   logic [7:0]                     shreg, shreg_next;
   logic                           par_err, par_err_next;
   logic                           frm_err, frm_err_next;
   logic [1:0]                     cfg_bits, cfg_mode;
   logic                           cfg_par, cfg_stop2;
   logic [CLOCK_DIVISOR_WIDTH-1:0] cfg_div;
   logic                           tick, exp_par;
   logic [CW-1:0]                  period_m1, half_m1;
   logic [2:0]                     last_idx;

   // Counter holds cycles-remaining minus one: P-1 = 4d+1, H-1 = 2d.
   assign period_m1 = {1'b0, cfg_div, 2'b01};
   assign half_m1   = {2'b00, clockDivisor, 1'b0};
   assign last_idx  = {1'b0, cfg_bits} + 3'd4;
   assign tick      = (cnt == '0);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rx_meta   <= 1'b1;
         rxs       <= 1'b1;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         par_err   <= 1'b0;
         frm_err   <= 1'b0;
         cfg_bits  <= '0;
         cfg_par   <= 1'b0;
         cfg_mode  <= '0;
         cfg_stop2 <= 1'b0;
         cfg_div   <= '0;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
         state   <= state_next;
         cnt     <= cnt_next;
         bit_idx <= bit_idx_next;
         shreg   <= shreg_next;
         par_err <= par_err_next;
         frm_err <= frm_err_next;
         // Tracks the inputs while idle, so it freezes on the cycle the frame starts.
         if (state == IDLE) begin
            cfg_bits  <= dataBits;
            cfg_par   <= hasParity;
            cfg_mode  <= parityMode;
            cfg_stop2 <= extraStopBit;
            cfg_div   <= clockDivisor;
         end
      end
   end

   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      bit_idx_next = bit_idx;
      shreg_next   = shreg;
      par_err_next = par_err;
      frm_err_next = frm_err;
      exp_par      = 1'b0;
      unique case (cfg_mode)
         2'b00:   exp_par = 1'b0;
         2'b11:   exp_par = 1'b1;
         2'b10:   exp_par = ^shreg;
         default: exp_par = ~^shreg;
      endcase
      if (state != IDLE && state != DONE && state != BREAKWAIT && !tick)
         cnt_next = cnt - 1'b1;
      case (state)
         IDLE: if (!rxs) begin
            state_next   = START;
            cnt_next     = half_m1;
            shreg_next   = '0;
            bit_idx_next = '0;
            par_err_next = 1'b0;
            frm_err_next = 1'b0;
         end
         START: if (tick) begin
            if (rxs) state_next = IDLE;
            else begin
               state_next   = DATA;
               cnt_next     = period_m1;
               bit_idx_next = '0;
            end
         end
         DATA: if (tick) begin
            shreg_next[bit_idx] = rxs;
            cnt_next            = period_m1;
            if (bit_idx == last_idx) state_next = cfg_par ? PAR : STOP1;
            else bit_idx_next = bit_idx + 3'd1;
         end
         PAR: if (tick) begin
            if (rxs != exp_par) par_err_next = 1'b1;
            cnt_next   = period_m1;
            state_next = STOP1;
         end
         STOP1: if (tick) begin
            if (!rxs) frm_err_next = 1'b1;
            cnt_next   = period_m1;
            state_next = cfg_stop2 ? STOP2 : DONE;
         end
         STOP2: if (tick) begin
            if (!rxs) frm_err_next = 1'b1;
            state_next = DONE;
         end
         // A line still low here is a break, not a new start bit.
         DONE:      state_next = rxs ? IDLE : BREAKWAIT;
         BREAKWAIT: if (rxs) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // valid/ack: valid rises with a completed frame and holds data and flags
   // until a cycle with valid & ack; a frame completing in that same cycle wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         data         <= '0;
         valid        <= 1'b0;
         parityError  <= 1'b0;
         framingError <= 1'b0;
         overrun      <= 1'b0;
      end else if (state == DONE) begin
         data         <= shreg;
         parityError  <= par_err;
         framingError <= frm_err;
         overrun      <= valid & ~ack;
         valid        <= 1'b1;
      end else if (valid && ack) begin
         valid        <= 1'b0;
         parityError  <= 1'b0;
         framingError <= 1'b0;
         overrun      <= 1'b0;
      end
   end
endmodule
